// File: rtl/demux_16_2_bit_loader.sv
// Sixteen 2-bit lane registers loaded through a valid/ready command port (write, fill, clear, burst).
// Define DEMUX16_READBACK_EN to add the rd_select/rd_data combinational readback port.
module demux_16_2_bit_loader #(
    parameter logic [1:0] RESET_VALUE = 2'b00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_select,
    input  logic [1:0] in_data,
    input  logic [3:0] in_len,
    output logic       busy,
    output logic       done,
    output logic [1:0] out0,
    output logic [1:0] out1,
    output logic [1:0] out2,
    output logic [1:0] out3,
    output logic [1:0] out4,
    output logic [1:0] out5,
    output logic [1:0] out6,
    output logic [1:0] out7,
    output logic [1:0] out8,
    output logic [1:0] out9,
    output logic [1:0] out10,
    output logic [1:0] out11,
    output logic [1:0] out12,
    output logic [1:0] out13,
    output logic [1:0] out14,
    output logic [1:0] out15
`ifdef DEMUX16_READBACK_EN
    ,
    input  logic [3:0] rd_select,
    output logic [1:0] rd_data
`endif
);

    typedef enum logic [1:0] {StIdle, StFill, StBurst} state_e;

    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpFill  = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;
    localparam logic [1:0] OpBurst = 2'b11;

    state_e           state_q, state_d;
    logic [15:0][1:0] lanes_q, lanes_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       rem_q, rem_d;
    logic [1:0]       fdata_q, fdata_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;

    assign in_ready = (state_q != StFill);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        fdata_d = fdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (in_op)
                        OpWrite: begin
                            lanes_d[in_select] = in_data;
                            done_d             = 1'b1;
                        end
                        OpClear: begin
                            lanes_d = {16{RESET_VALUE}};
                            done_d  = 1'b1;
                        end
                        OpFill: begin
                            lanes_d[in_select] = in_data;
                            fdata_d            = in_data;
                            ptr_d              = in_select + 4'd1;
                            // Filling from the last lane is a single write; no FILL phase.
                            if (in_select == 4'd15) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = StFill;
                            end
                        end
                        OpBurst: begin
                            ptr_d   = in_select;
                            rem_d   = in_len;
                            state_d = StBurst;
                        end
                        default: ;
                    endcase
                end
            end
            StFill: begin
                lanes_d[ptr_q] = fdata_q;
                ptr_d          = ptr_q + 4'd1;
                if (ptr_q == 4'd15) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StBurst: begin
                if (accept) begin
                    lanes_d[ptr_q] = in_data;
                    ptr_d          = ptr_q + 4'd1;
                    rem_d          = rem_q - 4'd1;
                    if (rem_q == 4'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Stays high through the done cycle of a multi-cycle command.
        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            lanes_q <= {16{RESET_VALUE}};
            ptr_q   <= 4'd0;
            rem_q   <= 4'd0;
            fdata_q <= 2'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            fdata_q <= fdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign done  = done_q;
    assign busy  = busy_q;
    assign out0  = lanes_q[0];
    assign out1  = lanes_q[1];
    assign out2  = lanes_q[2];
    assign out3  = lanes_q[3];
    assign out4  = lanes_q[4];
    assign out5  = lanes_q[5];
    assign out6  = lanes_q[6];
    assign out7  = lanes_q[7];
    assign out8  = lanes_q[8];
    assign out9  = lanes_q[9];
    assign out10 = lanes_q[10];
    assign out11 = lanes_q[11];
    assign out12 = lanes_q[12];
    assign out13 = lanes_q[13];
    assign out14 = lanes_q[14];
    assign out15 = lanes_q[15];

`ifdef DEMUX16_READBACK_EN
    assign rd_data = lanes_q[rd_select];
`endif

endmodule

// File: tb/tb_demux_16_2_bit_loader.sv
// Bench for demux_16_2_bit_loader: directed scenarios plus random traffic against a
// command-level lane model; readback checks compile in when DEMUX16_READBACK_EN is defined.
module tb_demux_16_2_bit_loader;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_select;
    logic [1:0] in_data;
    logic [3:0] in_len;
    logic       busy;
    logic       done;
    logic [1:0] dut_out [16];
`ifdef DEMUX16_READBACK_EN
    logic [3:0] rd_select;
    logic [1:0] rd_data;
`endif

    demux_16_2_bit_loader dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_select(in_select),
        .in_data  (in_data),
        .in_len   (in_len),
        .busy     (busy),
        .done     (done),
        .out0     (dut_out[0]),
        .out1     (dut_out[1]),
        .out2     (dut_out[2]),
        .out3     (dut_out[3]),
        .out4     (dut_out[4]),
        .out5     (dut_out[5]),
        .out6     (dut_out[6]),
        .out7     (dut_out[7]),
        .out8     (dut_out[8]),
        .out9     (dut_out[9]),
        .out10    (dut_out[10]),
        .out11    (dut_out[11]),
        .out12    (dut_out[12]),
        .out13    (dut_out[13]),
        .out14    (dut_out[14]),
        .out15    (dut_out[15])
`ifdef DEMUX16_READBACK_EN
        ,
        .rd_select(rd_select),
        .rd_data  (rd_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Command-level model: remaining fill writes and remaining burst data beats.
    logic [1:0] m_lanes [16];
    int         m_fill_left  = 0;
    int         m_fptr       = 0;
    logic [1:0] m_fdata      = 2'd0;
    int         m_burst_left = 0;
    int         m_bptr       = 0;
    bit         m_done       = 1'b0;
    bit         m_busy       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit was_active;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_lanes[i] = 2'b00;
            m_fill_left  = 0;
            m_burst_left = 0;
            m_done       = 1'b0;
            m_busy       = 1'b0;
            return;
        end
        was_active = (m_fill_left > 0) || (m_burst_left > 0);
        m_done = 1'b0;
        if (m_fill_left > 0) begin
            m_lanes[m_fptr] = m_fdata;
            m_fptr++;
            m_fill_left--;
            if (m_fill_left == 0) m_done = 1'b1;
        end else if (m_burst_left > 0) begin
            if (in_valid) begin
                m_lanes[m_bptr] = in_data;
                m_bptr = (m_bptr + 1) % 16;
                m_burst_left--;
                if (m_burst_left == 0) m_done = 1'b1;
            end
        end else if (in_valid) begin
            case (in_op)
                2'b00: begin
                    m_lanes[in_select] = in_data;
                    m_done = 1'b1;
                end
                2'b10: begin
                    for (int i = 0; i < 16; i++) m_lanes[i] = 2'b00;
                    m_done = 1'b1;
                end
                2'b01: begin
                    m_lanes[in_select] = in_data;
                    m_fill_left = 15 - int'(in_select);
                    m_fptr      = int'(in_select) + 1;
                    m_fdata     = in_data;
                    if (m_fill_left == 0) m_done = 1'b1;
                end
                default: begin
                    m_burst_left = int'(in_len) + 1;
                    m_bptr       = int'(in_select);
                end
            endcase
        end
        m_busy = was_active || (m_fill_left > 0) || (m_burst_left > 0);
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, (m_fill_left == 0));
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            for (int i = 0; i < 16; i++) chk($sformatf("out%0d", i), dut_out[i], m_lanes[i]);
`ifdef DEMUX16_READBACK_EN
            chk("rd_data", rd_data, m_lanes[rd_select]);
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic beat(input bit v, input logic [1:0] op, input logic [3:0] sel,
                        input logic [1:0] data, input logic [3:0] len);
        in_valid  = v;
        in_op     = op;
        in_select = sel;
        in_data   = data;
        in_len    = len;
        step();
    endtask

    task automatic idle();
        beat(1'b0, 2'b00, 4'd0, 2'd0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_lanes[i] = 2'b00;
        reset_n = 1'b0;
`ifdef DEMUX16_READBACK_EN
        rd_select = 4'd0;
`endif
        idle();
        idle();
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        chk("reset_out0", dut_out[0], 2'b00);
        chk("reset_out15", dut_out[15], 2'b00);
        chk("reset_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // WRITE sel=5 data=11
        beat(1'b1, 2'b00, 4'd5, 2'b11, 4'd0);
        chk("write_out5", dut_out[5], 2'b11);
        chk("write_model_out5", m_lanes[5], 2'b11);
        chk("write_out4", dut_out[4], 2'b00);
        chk("write_done", done, 1'b1);
        idle();
        chk("write_done_once", done, 1'b0);

        // FILL sel=12 data=10: ready low for three cycles
        beat(1'b1, 2'b01, 4'd12, 2'b10, 4'd0);
        chk("fill_ready_c1", in_ready, 1'b0);
        chk("fill_busy_c1", busy, 1'b1);
        idle();
        chk("fill_ready_c2", in_ready, 1'b0);
        idle();
        chk("fill_ready_c3", in_ready, 1'b0);
        chk("fill_done_early", done, 1'b0);
        idle();
        chk("fill_done", done, 1'b1);
        chk("fill_ready_back", in_ready, 1'b1);
        chk("fill_out12", dut_out[12], 2'b10);
        chk("fill_out15", dut_out[15], 2'b10);
        chk("fill_model_out15", m_lanes[15], 2'b10);
        chk("fill_out11", dut_out[11], 2'b00);
        chk("fill_out5_kept", dut_out[5], 2'b11);
        idle();

        // BURST sel=14 len=3 with a two-cycle valid gap after beat 2
        beat(1'b1, 2'b11, 4'd14, 2'b00, 4'd3);
        chk("burst_busy", busy, 1'b1);
        beat(1'b1, 2'b00, 4'd0, 2'b01, 4'd0);
        beat(1'b1, 2'b10, 4'd0, 2'b10, 4'd0);
        idle();
        idle();
        chk("burst_gap_busy", busy, 1'b1);
        chk("burst_gap_done", done, 1'b0);
        beat(1'b1, 2'b01, 4'd9, 2'b11, 4'd7);
        beat(1'b1, 2'b00, 4'd0, 2'b01, 4'd0);
        chk("burst_done", done, 1'b1);
        chk("burst_out14", dut_out[14], 2'b01);
        chk("burst_out15", dut_out[15], 2'b10);
        chk("burst_out0", dut_out[0], 2'b11);
        chk("burst_out1", dut_out[1], 2'b01);
        chk("burst_model_out0", m_lanes[0], 2'b11);
        chk("burst_out2_kept", dut_out[2], 2'b00);
        idle();
        chk("burst_busy_drop", busy, 1'b0);

        // Full 16-beat burst of 11, CLEAR, then WRITE in the CLEAR done cycle
        beat(1'b1, 2'b11, 4'd0, 2'b00, 4'd15);
        for (int i = 0; i < 16; i++) beat(1'b1, 2'b00, 4'd0, 2'b11, 4'd0);
        chk("full_done", done, 1'b1);
        chk("full_out7", dut_out[7], 2'b11);
        beat(1'b1, 2'b10, 4'd0, 2'b00, 4'd0);
        chk("clear_out7", dut_out[7], 2'b00);
        chk("clear_out15", dut_out[15], 2'b00);
        chk("clear_done", done, 1'b1);
        beat(1'b1, 2'b00, 4'd7, 2'b01, 4'd0);
        chk("b2b_write_out7", dut_out[7], 2'b01);
        chk("b2b_write_done", done, 1'b1);

        // Reset in the 4th cycle of FILL from sel=0
        beat(1'b1, 2'b01, 4'd0, 2'b10, 4'd0);
        idle();
        idle();
        idle();
        chk("prereset_out3", dut_out[3], 2'b10);
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        chk("abort_out0", dut_out[0], 2'b00);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        idle();
        idle();
        chk("abort_out4", dut_out[4], 2'b00);
        chk("abort_out15", dut_out[15], 2'b00);

`ifdef DEMUX16_READBACK_EN
        // Burst from lane 3 with beat i carrying i%4, then sweep rd_select
        beat(1'b1, 2'b11, 4'd3, 2'b00, 4'd15);
        for (int i = 0; i < 16; i++) beat(1'b1, 2'b00, 4'd0, 2'(i % 4), 4'd0);
        for (int s = 0; s < 16; s++) begin
            rd_select = 4'(s);
            #1;
            chk($sformatf("rd_sweep%0d", s), rd_data, 2'(((s + 13) % 16) % 4));
            chk($sformatf("rd_vs_out%0d", s), rd_data, dut_out[s]);
        end
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
`ifdef DEMUX16_READBACK_EN
            rd_select = 4'($urandom_range(0, 15));
`endif
            beat(1'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
        end
        reset_n = 1'b1;
        idle();
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
